// File: rtl/cobra_ctrl_pkg.sv
// Shared types and defaults for the CYBERcobra run/halt/step controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cobra_ctrl_pkg;

    // Controller states. The encoding is arbitrary. Only the state names
    // carry meaning.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } run_state_t;

    // Default program-counter and retired-instruction counter widths.
    localparam int unsigned PC_W_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 32;

    // The core is considered halted in IDLE and BREAK.
    function automatic logic is_halted_state(input run_state_t s);
        return (s == IDLE) || (s == BREAK);
    endfunction

endpackage

// File: rtl/cobra_edge_det.sv
// One-flop rising-edge detector for a signal already synchronous to clk_i.
// Latency: rise_o is combinational from d_i (same cycle as the low->high change).
// Backpressure: none; a level held high produces a single one-cycle pulse.
//
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset (history flop clears to 0)
//   d_i    - input level
//   rise_o - d_i & ~(d_i delayed by one cycle)
module cobra_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = d_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/cobra_run_ctrl.sv
// Run/halt/single-step controller producing the CYBERcobra core advance enable.
// Latency: en_o is combinational from state, pc_i and bp_*; halted_o/brk_o/instr_cnt_o are registered.
// Backpressure: none; a breakpoint drops en_o in the matching cycle, so the core stalls on that PC.
//
// Ports:
//   clk_i, rst_i  - core clock, asynchronous active-high reset
//   run_i         - free-run request level
//   step_i        - debounced step button; each rising edge executes one instruction
//   bp_en_i       - breakpoint enable
//   bp_addr_i     - breakpoint instruction address
//   pc_i          - PC of the instruction the core executes when en_o=1
//   clr_i         - synchronous clear of instr_cnt_o (wins over an increment)
//   en_o          - core advance enable for this cycle
//   halted_o      - 1 in IDLE and BREAK
//   brk_o         - 1 in BREAK
//   instr_cnt_o   - number of cycles with en_o=1, modulo 2^CNT_W
module cobra_run_ctrl
    import cobra_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             clr_i,
    output logic             en_o,
    output logic             halted_o,
    output logic             brk_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    run_state_t       state_q,  state_d;
    logic             skip_q,   skip_d;
    logic             halted_q, halted_d;
    logic             brk_q,    brk_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic step_rise;
    logic bp_hit;
    logic en;

    cobra_edge_det u_step_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (step_i),
        .rise_o (step_rise)
    );

    // skip_q masks the breakpoint for the first executed instruction after
    // leaving a halted state. Without it, resuming at the breakpoint PC
    // would trap again immediately.
    assign bp_hit = bp_en_i & (pc_i == bp_addr_i) & ~skip_q;

    // A breakpoint stops execution in the same cycle, so the instruction at
    // the breakpoint address is not executed.
    assign en = ((state_q == RUN) & ~bp_hit) | (state_q == STEP);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (step_rise) begin
                    state_d = STEP;
                end else if (run_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Dropping run_i takes priority over a breakpoint match.
                if (!run_i) begin
                    state_d = IDLE;
                end else if (bp_hit) begin
                    state_d = BREAK;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            BREAK: begin
                // Leaving BREAK for free-run needs run_i to drop first
                // (BREAK -> IDLE -> RUN).
                if (step_rise) begin
                    state_d = STEP;
                end else if (!run_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        skip_d = skip_q;
        if (en) begin
            skip_d = 1'b0;
        end else if (is_halted_state(state_q) && (state_d != state_q)) begin
            skip_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Status outputs are decoded from the next state and registered. They
    // therefore track the state register exactly, with no glitches.
    always_comb begin
        halted_d = is_halted_state(state_d);
        brk_d    = (state_d == BREAK);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            skip_q   <= 1'b0;
            halted_q <= 1'b1;
            brk_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            halted_q <= halted_d;
            brk_q    <= brk_d;
            cnt_q    <= cnt_d;
        end
    end

    assign en_o        = en;
    assign halted_o    = halted_q;
    assign brk_o       = brk_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: doc/cobra_run_ctrl.md
# cobra_run_ctrl

Run/halt/single-step controller for the CYBERcobra core. It produces the per-cycle advance enable that gates the core's PC update and register-file write. It halts the core on a PC breakpoint and counts retired instructions. It sits between the board-level controls (switches, debounced buttons) and the core, and lets the lab board free-run, single-step or stop at a chosen instruction address.

## Interface
- `PC_W`, default 32: width of the program counter and breakpoint address.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk_i`, input, 1: core clock.
- `rst_i`, input, 1: reset. Asynchronous, active-high.
- `run_i`, input, 1: level. 1 means free-run is requested.
- `step_i`, input, 1: debounced step button, synchronous to `clk_i`. Its rising edge requests one instruction.
- `bp_en_i`, input, 1: breakpoint enable.
- `bp_addr_i`, input, PC_W: breakpoint instruction address.
- `pc_i`, input, PC_W: the core's current PC, i.e. the instruction the core executes if `en_o`=1.
- `clr_i`, input, 1: synchronous clear of `instr_cnt_o`.
- `en_o`, output, 1: core advance enable for this cycle.
- `halted_o`, output, 1: 1 in the IDLE and BREAK states.
- `brk_o`, output, 1: 1 in the BREAK state.
- `instr_cnt_o`, output, CNT_W: number of cycles in which `en_o`=1.

## Operation
- The FSM has four states: IDLE, RUN, STEP, BREAK. The reset state is IDLE.
- `step_rise` = `step_i` & ~`step_q`. `step_q` is a register that resets to 0.
- `bp_hit` = `bp_en_i` & (`pc_i`==`bp_addr_i`) & ~`skip_q`.
- `en_o` is combinational: (state==RUN & ~`bp_hit`) | (state==STEP).
- IDLE:
  - `step_rise` → STEP. Step has priority over run.
  - else `run_i` → RUN.
  - else stay in IDLE.
- RUN:
  - ~`run_i` → IDLE. Halt has priority over a breakpoint.
  - else `bp_hit` → BREAK. `en_o`=0 in that cycle, so the breakpoint instruction is not executed.
  - else stay in RUN.
- STEP: always lasts exactly one cycle with `en_o`=1, then goes to IDLE. Breakpoints are ignored in STEP.
- BREAK:
  - `step_rise` → STEP.
  - else ~`run_i` → IDLE.
  - else stay in BREAK. The user must drop `run_i` and raise it again to resume.
- `skip_q`:
  - Set on every transition out of IDLE or BREAK. Resuming at the breakpoint address therefore executes that instruction.
  - Cleared in any cycle where `en_o`=1.
- `instr_cnt_o`:
  - Increments by 1 when `en_o`=1 and wraps modulo 2^CNT_W.
  - `clr_i` forces the value to 0. If `clr_i` and `en_o` are both 1 in the same cycle, the result is 0.
- `step_i` held high produces exactly one step. Another step needs a low→high transition.

## Timing
- All outputs at reset: `en_o`=0, `halted_o`=1, `brk_o`=0, `instr_cnt_o`=0. `skip_q`=0 and `step_q`=0.
- Asserting `rst_i` mid-operation immediately forces IDLE. In that same cycle `en_o`=0 and the counter is cleared.
- `step_rise` sampled at edge N → STEP in cycle N+1 with `en_o`=1 → IDLE in cycle N+2.
- `run_i` rising in IDLE → first `en_o`=1 in the next cycle.
- `run_i` falling in RUN → `en_o` stays 1 in the current cycle, then 0 from the next cycle.
- A breakpoint is detected in the same cycle `pc_i` matches: `en_o` drops to 0 combinationally, and `brk_o` is 1 from the next cycle.
- `halted_o` and `brk_o` are decoded from state (registered). Only `en_o` is combinational from `pc_i`, `bp_*` and state.

## Structure
- Package `cobra_ctrl_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, STEP, BREAK} run_state_t`.
  - Default PC and counter widths as localparams.
- Sub-module `cobra_edge_det`: one-flop rising-edge detector with async active-high reset, used for `step_i`.
- The rest (next-state logic, skip flag, counter) is a single module.

## Test plan
- Reset, then `run_i`=1 with `bp_en_i`=0 for 20 cycles → `en_o`=1 from cycle 2; `instr_cnt_o`=20 one cycle after the 20th enable; `halted_o`=0.
- `bp_en_i`=1, `bp_addr_i`=0x10, `pc_i` counts 0,4,8,… and advances only when `en_o`=1 → `en_o`=0 when `pc_i`=0x10; `brk_o`=1 next cycle; `instr_cnt_o`=4.
- From BREAK at 0x10: drop `run_i` for 1 cycle, then raise it → the first RUN cycle at `pc_i`=0x10 gives `en_o`=1 (skip); count becomes 5.
- In IDLE, hold `step_i` high for 10 cycles → exactly one `en_o` pulse; count +1; back to IDLE. Toggle `step_i` 3 times → 3 pulses.
- `step_rise` and `run_i` rise in the same cycle in IDLE → STEP first (one pulse), then IDLE, then RUN.
- Assert `rst_i` mid-RUN between clock edges → `en_o`=0, `halted_o`=1 and `instr_cnt_o`=0 without waiting for a clock edge.
- Preload the counter to 0xFFFFFFFF via enables, then one more enable → counter wraps to 0. Assert `clr_i` together with `en_o` → counter is 0.
